// File: rtl/eth_tx_sched_pkg.sv
// Shared types and helpers for the Ethernet TX frame scheduler.
// The optional stall timeout is enabled by ETH_TX_SCHED_TIMEOUT_EN.
package eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ABORT
  } sched_state_t;

  localparam int MAX_S = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int TIMEOUT_W = $clog2(DEF_TIMEOUT_CYCLES + 1);

  // First set bit at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_S-1:0] req,
    input logic [3:0]       ptr,
    input int               n
  );
    logic [3:0] idx;
    logic       found;
    int         j;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_S; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !found && j < MAX_S) begin
        if (req[j[3:0]]) begin
          idx   = j[3:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/eth_tx_frame_sched_arb.sv
// Combinational rotating-priority pick over S_COUNT requesters.
// Shared by the frame scheduler; timeout macro ETH_TX_SCHED_TIMEOUT_EN unused here.
module eth_tx_rr_arbiter
  import eth_tx_sched_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int GRANT_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               any,
  output logic [GRANT_W-1:0] idx
);

  logic [MAX_S-1:0] req_x;
  logic [3:0]       pick;

  assign req_x = MAX_S'(req);
  assign pick  = rr_pick(req_x, 4'(rr_ptr), S_COUNT);
  assign any   = |req;
  assign idx   = GRANT_W'(pick);

endmodule

// File: rtl/eth_tx_frame_sched.sv
// Frame-granular round-robin scheduler onto the 8-bit MAC TX stream.
// Define ETH_TX_SCHED_TIMEOUT_EN to abort frames stalled mid-transfer.
module eth_tx_frame_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int S_COUNT        = 4,
  parameter int GRANT_W        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst,
  input  logic [8*S_COUNT-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]   s_axis_tvalid,
  output logic [S_COUNT-1:0]   s_axis_tready,
  input  logic [S_COUNT-1:0]   s_axis_tlast,
  input  logic [S_COUNT-1:0]   s_axis_tuser,
  input  logic [S_COUNT-1:0]   src_enable,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 grant_valid,
  output logic [GRANT_W-1:0]   grant_idx,
  output logic                 frame_done,
  output logic                 frame_abort
);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] rr_inc;
  logic [GRANT_W-1:0] arb_idx;
  logic [S_COUNT-1:0] req;
  logic               arb_any;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               sel_user;
  logic               take;
  logic               frame_end;
  logic               leave;

  assign req = s_axis_tvalid & src_enable;

  eth_tx_rr_arbiter #(
    .S_COUNT (S_COUNT),
    .GRANT_W (GRANT_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (arb_any),
    .idx    (arb_idx)
  );

  assign sel_data  = s_axis_tdata[{grant_idx, 3'b000} +: 8];
  assign sel_valid = s_axis_tvalid[grant_idx];
  assign sel_last  = s_axis_tlast[grant_idx];
  assign sel_user  = s_axis_tuser[grant_idx];

  assign rr_inc = (grant_idx == GRANT_W'(S_COUNT - 1)) ?
                  '0 : grant_idx + 1'b1;

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > TIMEOUT_W) ?
                         $clog2(TIMEOUT_CYCLES + 1) : TIMEOUT_W;

  logic [CNT_W-1:0] stall_cnt;
  logic             abort_end;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      stall_cnt <= '0;
    end else if (state == XFER && !sel_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort_end;
    end
  end

  assign leave = frame_end | abort_end;
`else
  assign frame_abort = 1'b0;
  assign leave       = frame_end;
`endif

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    frame_end     = 1'b0;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
    abort_end     = 1'b0;
`endif
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          state_nxt = XFER;
          take      = 1'b1;
        end
      end
      XFER: begin
        m_axis_tdata             = sel_data;
        m_axis_tvalid            = sel_valid;
        m_axis_tlast             = sel_last;
        m_axis_tuser             = sel_user;
        s_axis_tready[grant_idx] = m_axis_tready;
        if (sel_valid && m_axis_tready && sel_last) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
`ifdef ETH_TX_SCHED_TIMEOUT_EN
        else if (!sel_valid &&
                 stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = ABORT;
        end
`endif
      end
`ifdef ETH_TX_SCHED_TIMEOUT_EN
      // Synthetic terminating beat so the MAC drops the partial frame.
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          state_nxt = IDLE;
          abort_end = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (take) begin
        grant_valid <= 1'b1;
        grant_idx   <= arb_idx;
      end
      if (leave) begin
        grant_valid <= 1'b0;
        rr_ptr      <= rr_inc;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Directed bench for eth_tx_frame_sched with a per-source frame model.
// Timeout scenario runs only when ETH_TX_SCHED_TIMEOUT_EN is defined.
module tb_eth_tx_frame_sched;

  localparam int S  = 4;
  localparam int GW = 2;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic           tx_clk = 1'b0;
  logic           tx_rst;
  logic [8*S-1:0] s_tdata;
  logic [S-1:0]   s_tvalid;
  logic [S-1:0]   s_tready;
  logic [S-1:0]   s_tlast;
  logic [S-1:0]   s_tuser;
  logic [S-1:0]   src_en;
  logic [7:0]     m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic           m_tlast;
  logic           m_tuser;
  logic           grant_valid;
  logic [GW-1:0]  grant_idx;
  logic           frame_done;
  logic           frame_abort;

  int checks = 0;
  int errors = 0;

  always #5 tx_clk = ~tx_clk;

  eth_tx_frame_sched #(
    .S_COUNT        (S),
    .GRANT_W        (GW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .src_enable    (src_en),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .frame_done    (frame_done),
    .frame_abort   (frame_abort)
  );

  // Source model: byte value = position in frame.
  int   pos[S];
  int   done[S];
  int   req_n[S];
  int   flen[S];
  int   pause_at[S];
  logic flush = 1'b0;

  always_comb begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    s_tdata  = '0;
    for (int i = 0; i < S; i++) begin
      s_tvalid[i]       = (req_n[i] > done[i]) && (pos[i] != pause_at[i]);
      s_tlast[i]        = (pos[i] == flen[i] - 1);
      s_tdata[8*i +: 8] = 8'(pos[i]);
    end
  end

  always @(posedge tx_clk) begin
    for (int i = 0; i < S; i++) begin
      if (flush) begin
        pos[i]  <= 0;
        done[i] <= 0;
      end else if (s_tvalid[i] && s_tready[i]) begin
        if (s_tlast[i]) begin
          pos[i]  <= 0;
          done[i] <= done[i] + 1;
        end else begin
          pos[i] <= pos[i] + 1;
        end
      end
    end
  end

  // Beat log sampled mid-cycle.
  int cyc = 0;
  int b_src[$];
  int b_data[$];
  int b_cyc[$];
  bit b_last[$];
  bit b_user[$];
  int done_cyc[$];
  int abort_n = 0;

  always @(posedge tx_clk) cyc <= cyc + 1;

  always @(negedge tx_clk) begin
    if (m_tvalid && m_tready && !tx_rst) begin
      b_src.push_back(int'(grant_idx));
      b_data.push_back(int'(m_tdata));
      b_cyc.push_back(cyc);
      b_last.push_back(m_tlast);
      b_user.push_back(m_tuser);
    end
    if (frame_done) done_cyc.push_back(cyc);
    if (frame_abort) abort_n++;
  end

  task automatic clear_log();
    b_src.delete();
    b_data.delete();
    b_cyc.delete();
    b_last.delete();
    b_user.delete();
    done_cyc.delete();
    abort_n = 0;
  endtask

  task automatic wait_beats(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge tx_clk);
      #1;
      if (b_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge tx_clk);
    #2;
    tx_rst   = 1'b1;
    flush    = 1'b1;
    m_tready = 1'b0;
    src_en   = '1;
    for (int i = 0; i < S; i++) begin
      req_n[i]    = 0;
      flen[i]     = 1;
      pause_at[i] = -1;
    end
    repeat (3) @(posedge tx_clk);
    #2;
    flush  = 1'b0;
    tx_rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    tx_rst   = 1'b1;
    m_tready = 1'b1;
    src_en   = '1;
    for (int i = 0; i < S; i++) begin
      req_n[i]    = 1;
      flen[i]     = 4;
      pause_at[i] = -1;
    end
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid: got %b, want 0", m_tvalid);
    end
    checks++;
    if (grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant_valid: got %b, want 0", grant_valid);
    end
    checks++;
    if (grant_idx !== '0) begin
      errors++;
      $display("FAIL reset_grant_idx: got %0d, want 0", grant_idx);
    end
    checks++;
    if (s_tready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, want 0000", s_tready);
    end
    checks++;
    if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got done=%b abort=%b, want 0 0",
               frame_done, frame_abort);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int bad;
    apply_reset();
    m_tready = 1'b1;
    flen[2]  = 60;
    req_n[2] = 1;
    wait_beats(60, 300, ok);
    repeat (4) @(negedge tx_clk);
    checks++;
    if (!ok || b_data.size() != 60) begin
      errors++;
      $display("FAIL single_count: got %0d beats, want 60", b_data.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 60; k++)
        if (b_data[k] != k || b_src[k] != 2 || b_last[k] != (k == 59))
          bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_beats: %0d bad beats, want 0", bad);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != b_cyc[59] + 1) begin
        errors++;
        $display("FAIL single_done: got %0d pulses, want 1 at cycle %0d",
                 done_cyc.size(), b_cyc[59] + 1);
      end
    end
    checks++;
    if (grant_idx !== 2'd2 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant_hold: got idx=%0d gv=%b, want 2 0",
               grant_idx, grant_valid);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int bad;
    apply_reset();
    m_tready = 1'b1;
    for (int i = 0; i < S; i++) begin
      flen[i]  = 64;
      req_n[i] = 2;
    end
    wait_beats(512, 1500, ok);
    repeat (3) @(negedge tx_clk);
    checks++;
    if (!ok || b_data.size() != 512) begin
      errors++;
      $display("FAIL fair_count: got %0d beats, want 512", b_data.size());
    end else begin
      for (int f = 0; f < 8; f++) begin
        bad = 0;
        for (int k = 0; k < 64; k++)
          if (b_src[64*f+k] != f % 4 || b_data[64*f+k] != k ||
              b_last[64*f+k] != (k == 63))
            bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL fair_frame%0d: src %0d, %0d bad beats, want src %0d",
                   f, b_src[64*f], bad, f % 4);
        end
      end
      bad = 0;
      for (int f = 1; f < 8; f++)
        if (b_cyc[64*f] - b_cyc[64*f-1] != 2) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL fair_gap: %0d gaps not 1 idle cycle, want 0", bad);
      end
    end
    checks++;
    if (done_cyc.size() != 8) begin
      errors++;
      $display("FAIL fair_done: got %0d pulses, want 8", done_cyc.size());
    end
  endtask

  task automatic test_enable_mask();
    bit ok;
    int bad;
    int exp_src[6];
    exp_src = '{1, 3, 1, 3, 3, 3};
    apply_reset();
    m_tready = 1'b1;
    src_en   = 4'b1010;
    for (int i = 0; i < S; i++) begin
      flen[i]  = 8;
      req_n[i] = 5;
    end
    wait_beats(19, 200, ok);
    @(posedge tx_clk);
    #2;
    src_en = 4'b1000;
    wait_beats(48, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL enable_count: got %0d beats, want 48", b_data.size());
    end else begin
      for (int f = 0; f < 6; f++) begin
        bad = 0;
        for (int k = 0; k < 8; k++)
          if (b_src[8*f+k] != exp_src[f] || b_data[8*f+k] != k) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL enable_frame%0d: src %0d, %0d bad beats, want src %0d",
                   f, b_src[8*f], bad, exp_src[f]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    logic [S-1:0] want;
    apply_reset();
    m_tready = 1'b1;
    flen[1]  = 100;
    req_n[1] = 1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge tx_clk);
      #2;
      m_tready = ~m_tready;
      @(negedge tx_clk);
      want = grant_valid ? {2'b00, m_tready, 1'b0} : 4'b0000;
      checks++;
      if (s_tready !== want) begin
        errors++;
        $display("FAIL bp_tready c%0d: got %b, want %b", c, s_tready, want);
      end
      #1;
      if (b_data.size() >= 100) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || b_data.size() != 100) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, want 100", b_data.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 100; k++)
        if (b_data[k] != k || b_src[k] != 1 || b_last[k] != (k == 99))
          bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL bp_beats: %0d bad beats, want 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    apply_reset();
    m_tready = 1'b1;
    flen[1]  = 4;
    req_n[1] = 1;
    wait_beats(4, 50, ok);
    repeat (2) @(negedge tx_clk);
    flen[2]  = 60;
    req_n[2] = 1;
    wait_beats(24, 200, ok);
    checks++;
    if (!ok || b_src[23] != 2) begin
      errors++;
      $display("FAIL rstmid_setup: got %0d beats, want 24 from src 2",
               b_data.size());
    end
    #2;
    tx_rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || grant_valid !== 1'b0 || s_tready !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got tv=%b gv=%b rdy=%b, want 0 0 0000",
               m_tvalid, grant_valid, s_tready);
    end
    @(posedge tx_clk);
    #2;
    flush = 1'b1;
    for (int i = 0; i < S; i++) req_n[i] = 0;
    @(posedge tx_clk);
    #2;
    flush = 1'b0;
    clear_log();
    for (int i = 0; i < S; i++) begin
      flen[i]  = 4;
      req_n[i] = 1;
    end
    tx_rst = 1'b0;
    wait_beats(4, 50, ok);
    checks++;
    if (!ok || b_src[0] != 0 || b_data[0] != 0) begin
      errors++;
      $display("FAIL rstmid_restart: got %0d beats, first src %0d, want src 0",
               b_data.size(), ok ? b_src[0] : -1);
    end
  endtask

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit seen;
    int stall;
    apply_reset();
    m_tready    = 1'b1;
    flen[1]     = 30;
    pause_at[1] = 10;
    req_n[1]    = 1;
    flen[2]     = 4;
    req_n[2]    = 1;
    wait_beats(10, 100, ok);
    stall = 0;
    seen  = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge tx_clk);
      if (grant_valid && !m_tvalid) stall++;
      if (m_tvalid && m_tlast && m_tuser) begin
        seen = 1'b1;
        checks++;
        if (m_tdata !== 8'h00 || s_tready !== '0) begin
          errors++;
          $display("FAIL to_beat: got data=%h rdy=%b, want 00 0000",
                   m_tdata, s_tready);
        end
      end
    end
    checks++;
    if (!seen || stall != 8) begin
      errors++;
      $display("FAIL to_stall: got %0d stall cycles seen=%b, want 8", stall, seen);
    end
    @(negedge tx_clk);
    checks++;
    if (frame_abort !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: got abort=%b done=%b, want 1 0",
               frame_abort, frame_done);
    end
    wait_beats(15, 100, ok);
    checks++;
    if (!ok || b_src[11] != 2 || b_data[11] != 0 || b_data[14] != 3) begin
      errors++;
      $display("FAIL to_next: got %0d beats, next src %0d, want src 2",
               b_data.size(), ok ? b_src[11] : -1);
    end
    checks++;
    if (abort_n != 1) begin
      errors++;
      $display("FAIL to_abort_count: got %0d, want 1", abort_n);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tx_rst   = 1'b1;
    m_tready = 1'b0;
    src_en   = '1;
    for (int i = 0; i < S; i++) begin
      req_n[i]    = 0;
      flen[i]     = 1;
      pause_at[i] = -1;
    end
    test_reset();
    test_single_frame();
    test_fairness();
    test_enable_mask();
    test_backpressure();
    test_reset_mid_frame();
`ifdef ETH_TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
